// File: rtl/huffman_pkg.sv
// Shared definitions for the serial Huffman decoder: symbol values, table
// geometry, FSM state encoding and the code-length to mask helper.
package huffman_pkg;

    localparam int CODE_W  = 8;
    localparam int NUM_ENT = 6;

    localparam logic [CODE_W-1:0] A1 = 8'd1;
    localparam logic [CODE_W-1:0] A2 = 8'd2;
    localparam logic [CODE_W-1:0] A3 = 8'd3;
    localparam logic [CODE_W-1:0] A4 = 8'd4;
    localparam logic [CODE_W-1:0] A5 = 8'd5;
    localparam logic [CODE_W-1:0] A6 = 8'd6;

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_e;

    // Right-aligned run of 'len' ones; len = 0 yields 8'h00, which never
    // equals a used mask, so an empty accumulator can never match.
    function automatic logic [CODE_W-1:0] len_mask(input logic [3:0] len);
        logic [3:0] sh;
        sh = 4'd8 - len;
        return 8'hFF >> sh;
    endfunction

endpackage

// File: rtl/huffman_entry_match.sv
// One code-table entry: flags a hit when the accumulated bits have exactly
// this entry's length and the masked value equals its codeword.
module huffman_entry_match
    import huffman_pkg::*;
(
    input  logic [CODE_W-1:0] hc,
    input  logic [CODE_W-1:0] m,
    input  logic [CODE_W-1:0] acc_n,
    input  logic [3:0]        len_n,
    output logic              hit
);

    assign hit = (m != '0)
              && (m == len_mask(len_n))
              && ((acc_n & m) == hc);

endmodule

// File: rtl/huffman_decoder.sv
// Serial Huffman decoder: latches a 6-entry code table, shifts in an
// MSB-first bitstream and emits one symbol per codeword, flags codewords of
// MAX_LEN bits that match nothing, and counts symbols per frame.
module huffman_decoder
    import huffman_pkg::*;
#(
    parameter int MAX_LEN = 5,
    parameter int NUM_SYM = 100
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              code_valid,
    input  logic [CODE_W-1:0] HC1,
    input  logic [CODE_W-1:0] HC2,
    input  logic [CODE_W-1:0] HC3,
    input  logic [CODE_W-1:0] HC4,
    input  logic [CODE_W-1:0] HC5,
    input  logic [CODE_W-1:0] HC6,
    input  logic [CODE_W-1:0] M1,
    input  logic [CODE_W-1:0] M2,
    input  logic [CODE_W-1:0] M3,
    input  logic [CODE_W-1:0] M4,
    input  logic [CODE_W-1:0] M5,
    input  logic [CODE_W-1:0] M6,
    input  logic              bit_valid,
    input  logic              bit_in,
    output logic              sym_valid,
    output logic [CODE_W-1:0] sym_data,
    output logic              sym_err,
    output logic [6:0]        sym_cnt,
    output logic              done
);

    state_e            state_q;
    logic [CODE_W-1:0] hc_q  [NUM_ENT];
    logic [CODE_W-1:0] m_q   [NUM_ENT];
    logic [CODE_W-1:0] hc_in [NUM_ENT];
    logic [CODE_W-1:0] m_in  [NUM_ENT];
    logic [CODE_W-1:0] acc_q;
    logic [3:0]        len_q;
    logic              sym_valid_q;
    logic [CODE_W-1:0] sym_data_q;
    logic              sym_err_q;
    logic [6:0]        sym_cnt_q;
    logic              done_q;

    logic [CODE_W-1:0] acc_d;
    logic [3:0]        len_d;
    logic [NUM_ENT-1:0] hit;
    logic              any_hit;
    logic [CODE_W-1:0] hit_sym;
    logic [6:0]        cnt_base;
    logic [6:0]        cnt_inc;
    logic              len_full;

    assign hc_in[0] = HC1;
    assign hc_in[1] = HC2;
    assign hc_in[2] = HC3;
    assign hc_in[3] = HC4;
    assign hc_in[4] = HC5;
    assign hc_in[5] = HC6;
    assign m_in[0]  = M1;
    assign m_in[1]  = M2;
    assign m_in[2]  = M3;
    assign m_in[3]  = M4;
    assign m_in[4]  = M5;
    assign m_in[5]  = M6;

    // Candidate accumulator/length if the current bit is accepted.
    assign acc_d    = (acc_q << 1) | {{(CODE_W-1){1'b0}}, bit_in};
    assign len_d    = len_q + 4'd1;
    assign len_full = (len_d == 4'(MAX_LEN));

    for (genvar g = 0; g < NUM_ENT; g++) begin : g_ent
        huffman_entry_match u_match (
            .hc    (hc_q[g]),
            .m     (m_q[g]),
            .acc_n (acc_d),
            .len_n (len_d),
            .hit   (hit[g])
        );
    end

    // Priority encoder: scan downwards so the lowest matching index wins.
    always_comb begin
        any_hit = 1'b0;
        hit_sym = '0;
        for (int i = NUM_ENT - 1; i >= 0; i--) begin
            if (hit[i]) begin
                any_hit = 1'b1;
                hit_sym = CODE_W'(i + 1);
            end
        end
    end

    // A count sitting at NUM_SYM is the previous frame's final value, so the
    // new frame counts from zero without a reload.
    assign cnt_base = (sym_cnt_q == 7'(NUM_SYM)) ? 7'd0 : sym_cnt_q;
    assign cnt_inc  = cnt_base + 7'd1;

    // Control FSM with table, accumulator and registered output strobes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            for (int i = 0; i < NUM_ENT; i++) begin
                hc_q[i] <= '0;
                m_q[i]  <= '0;
            end
            acc_q       <= '0;
            len_q       <= '0;
            sym_valid_q <= 1'b0;
            sym_data_q  <= '0;
            sym_err_q   <= 1'b0;
            sym_cnt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            sym_valid_q <= 1'b0;
            sym_err_q   <= 1'b0;
            done_q      <= 1'b0;
            sym_cnt_q   <= cnt_base;
            if (code_valid) begin
                // Table load wins over any bit arriving in the same cycle.
                for (int i = 0; i < NUM_ENT; i++) begin
                    hc_q[i] <= hc_in[i];
                    m_q[i]  <= m_in[i];
                end
                acc_q     <= '0;
                len_q     <= '0;
                sym_cnt_q <= '0;
                state_q   <= ST_RUN;
            end else if (state_q == ST_RUN && bit_valid) begin
                if (any_hit) begin
                    sym_valid_q <= 1'b1;
                    sym_data_q  <= hit_sym;
                    sym_cnt_q   <= cnt_inc;
                    done_q      <= (cnt_inc == 7'(NUM_SYM));
                    acc_q       <= '0;
                    len_q       <= '0;
                end else if (len_full) begin
                    sym_err_q <= 1'b1;
                    acc_q     <= '0;
                    len_q     <= '0;
                end else begin
                    acc_q <= acc_d;
                    len_q <= len_d;
                end
            end
        end
    end

    assign sym_valid = sym_valid_q;
    assign sym_data  = sym_data_q;
    assign sym_err   = sym_err_q;
    assign sym_cnt   = sym_cnt_q;
    assign done      = done_q;

endmodule
